// File: rtl/tb_scheduler_if.sv
// ACS / TBU control bundle for the traceback scheduler.
// master = ACS + TBU side, slave = scheduler.
interface tb_scheduler_if #(
   parameter int unsigned WD_FSM   = 6,
   parameter int unsigned WD_STATE = 8
);
   logic                AcsValid;
   logic                AcsReady;
   logic                FrameEnd;
   logic [WD_STATE-1:0] BestState;
   logic [WD_FSM-1:0]   WrPage;
   logic [WD_FSM-1:0]   TbPage;
   logic                TB_EN;
   logic                Init;
   logic                Hold;
   logic [WD_STATE-1:0] InitState;
   logic                DecodedValid;
   logic                FrameDone;

   modport master (
      output AcsValid, FrameEnd, BestState,
      input  AcsReady, WrPage, TbPage, TB_EN, Init, Hold, InitState, DecodedValid, FrameDone
   );

   modport slave (
      input  AcsValid, FrameEnd, BestState,
      output AcsReady, WrPage, TbPage, TB_EN, Init, Hold, InitState, DecodedValid, FrameDone
   );
endinterface

// File: rtl/tb_scheduler.sv
// Viterbi survivor-RAM / traceback sequencer: page bookkeeping, one traceback per
// trellis step once the window is full, and shrinking-depth flushes at frame end.
module tb_scheduler #(
   parameter int unsigned WD_FSM    = 6,
   parameter int unsigned WD_STATE  = 8,
   parameter int unsigned TB_DEPTH  = 63,
   parameter int unsigned ZERO_TAIL = 1
) (
   input logic           Clock,
   input logic           Reset,
   tb_scheduler_if.slave bus
);
   localparam logic [WD_FSM-1:0] PAGE_ONE    = WD_FSM'(1);
   localparam logic [WD_FSM-1:0] DEPTH_FULL  = WD_FSM'(TB_DEPTH);
   localparam logic [WD_FSM-1:0] DEPTH_FLUSH = WD_FSM'(TB_DEPTH - 1);
   localparam bit                ZERO_START  = (ZERO_TAIL != 0);

   typedef enum logic [1:0] {FILL, TRACE, FLUSH} state_t;

   state_t              state, stateNext;
   logic [WD_FSM-1:0]   wrPage, wrPageNext;
   logic [WD_FSM-1:0]   fillCount, fillCountNext;
   logic [WD_FSM-1:0]   startPage, startPageNext;
   logic [WD_FSM-1:0]   depth, depthNext;
   logic [WD_FSM-1:0]   stepIdx, stepIdxNext;
   logic [WD_FSM-1:0]   tbPage, tbPageNext;
   logic [WD_STATE-1:0] initState, initStateNext;
   logic [WD_STATE-1:0] bestLatch, bestLatchNext;
   logic                flushPend, flushPendNext;
   logic                tbEn, tbEnNext;
   logic                initStep, initStepNext;
   logic                hold, holdNext;
   logic                decValid, decValidNext;
   logic                frameDone, frameDoneNext;
   logic                acsReady, acsReadyNext;
   logic                launch;
   logic [WD_FSM-1:0]   launchDepth;
   logic [WD_FSM-1:0]   countInc;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= FILL;
         wrPage    <= '0;
         fillCount <= '0;
         startPage <= '0;
         depth     <= '0;
         stepIdx   <= '0;
         tbPage    <= '0;
         initState <= '0;
         bestLatch <= '0;
         flushPend <= 1'b0;
         tbEn      <= 1'b0;
         initStep  <= 1'b0;
         hold      <= 1'b0;
         decValid  <= 1'b0;
         frameDone <= 1'b0;
         acsReady  <= 1'b1;
      end else begin
         state     <= stateNext;
         wrPage    <= wrPageNext;
         fillCount <= fillCountNext;
         startPage <= startPageNext;
         depth     <= depthNext;
         stepIdx   <= stepIdxNext;
         tbPage    <= tbPageNext;
         initState <= initStateNext;
         bestLatch <= bestLatchNext;
         flushPend <= flushPendNext;
         tbEn      <= tbEnNext;
         initStep  <= initStepNext;
         hold      <= holdNext;
         decValid  <= decValidNext;
         frameDone <= frameDoneNext;
         acsReady  <= acsReadyNext;
      end
   end

   // Next-state and next-output logic; a launch starts a traceback at step 0 next cycle.
   always_comb begin
      stateNext     = state;
      wrPageNext    = wrPage;
      fillCountNext = fillCount;
      startPageNext = startPage;
      depthNext     = depth;
      stepIdxNext   = stepIdx;
      tbPageNext    = tbPage;
      initStateNext = initState;
      bestLatchNext = bestLatch;
      flushPendNext = flushPend;
      tbEnNext      = 1'b0;
      initStepNext  = 1'b0;
      holdNext      = 1'b0;
      decValidNext  = hold;
      frameDoneNext = hold && (state == FLUSH) && (depth == PAGE_ONE);
      launch        = 1'b0;
      launchDepth   = depth;
      countInc      = (fillCount >= DEPTH_FULL) ? fillCount : fillCount + PAGE_ONE;

      case (state)
         FILL: begin
            if (bus.AcsValid && acsReady) begin
               wrPageNext    = wrPage + PAGE_ONE;
               fillCountNext = countInc;
               startPageNext = wrPage;
               bestLatchNext = bus.BestState;
               if (countInc == DEPTH_FULL) begin
                  stateNext     = TRACE;
                  flushPendNext = bus.FrameEnd;
                  initStateNext = bus.BestState;
                  launch        = 1'b1;
                  launchDepth   = DEPTH_FULL;
               end else if (bus.FrameEnd) begin
                  // Short frame: window never filled, flush what is stored.
                  stateNext     = FLUSH;
                  initStateNext = ZERO_START ? '0 : bus.BestState;
                  launch        = 1'b1;
                  launchDepth   = countInc;
               end
            end
         end
         TRACE, FLUSH: begin
            if (!hold) begin
               tbEnNext    = 1'b1;
               tbPageNext  = startPage - stepIdx;
               holdNext    = (stepIdx == depth - PAGE_ONE);
               stepIdxNext = stepIdx + PAGE_ONE;
            end else if ((state == TRACE) && flushPend) begin
               stateNext     = FLUSH;
               flushPendNext = 1'b0;
               initStateNext = ZERO_START ? '0 : bestLatch;
               launch        = 1'b1;
               launchDepth   = DEPTH_FLUSH;
            end else if ((state == FLUSH) && (depth != PAGE_ONE)) begin
               launch      = 1'b1;
               launchDepth = depth - PAGE_ONE;
            end else begin
               stateNext = FILL;
               if (state == FLUSH) fillCountNext = '0;
            end
         end
         default: stateNext = FILL;
      endcase

      if (launch) begin
         depthNext    = launchDepth;
         tbEnNext     = 1'b1;
         initStepNext = 1'b1;
         holdNext     = (launchDepth == PAGE_ONE);
         tbPageNext   = startPageNext;
         stepIdxNext  = PAGE_ONE;
      end

      acsReadyNext = (stateNext == FILL);
   end

   assign bus.AcsReady     = acsReady;
   assign bus.WrPage       = wrPage;
   assign bus.TbPage       = tbPage;
   assign bus.TB_EN        = tbEn;
   assign bus.Init         = initStep;
   assign bus.Hold         = hold;
   assign bus.InitState    = initState;
   assign bus.DecodedValid = decValid;
   assign bus.FrameDone    = frameDone;
endmodule

// File: tb/tb_tb_scheduler.sv
// Scoreboard bench for tb_scheduler: driver pushes expected tracebacks from a
// per-step model, monitor pops and checks each traceback the DUT emits.
module tb_tb_scheduler;
   localparam int unsigned WD_FSM    = 3;
   localparam int unsigned WD_STATE  = 8;
   localparam int unsigned TB_DEPTH  = 4;
   localparam int unsigned ZERO_TAIL = 1;
   localparam int          PAGES     = 1 << WD_FSM;
   localparam int          DEPTH     = int'(TB_DEPTH);

   logic Clock = 1'b0;
   logic Reset = 1'b0;
   always #5 Clock = ~Clock;

   tb_scheduler_if #(.WD_FSM(WD_FSM), .WD_STATE(WD_STATE)) bus ();

   tb_scheduler #(
      .WD_FSM(WD_FSM), .WD_STATE(WD_STATE), .TB_DEPTH(TB_DEPTH), .ZERO_TAIL(ZERO_TAIL)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus)
   );

   typedef struct {
      int start;
      int depth;
      int initSt;
      bit done;
   } trace_t;

   trace_t expQ[$];
   int     checks    = 0;
   int     errors    = 0;
   int     dvCount   = 0;
   int     doneCount = 0;
   int     mWrPage   = 0;
   int     mCount    = 0;
   trace_t cur;
   bit     active    = 1'b0;
   int     k         = 0;
   bit     dvExp     = 1'b0;
   bit     doneExp   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   // Reference: each accepted step yields the list of tracebacks it causes.
   task automatic modelAccept(input bit fe, input int best);
      int page;
      int first;
      page    = mWrPage;
      mWrPage = (mWrPage + 1) % PAGES;
      mCount  = (mCount + 1 > DEPTH) ? DEPTH : mCount + 1;
      if (mCount == DEPTH) expQ.push_back('{page, DEPTH, best, 1'b0});
      if (fe) begin
         first = (mCount == DEPTH) ? DEPTH - 1 : mCount;
         for (int d = first; d >= 1; d--)
            expQ.push_back('{page, d, (ZERO_TAIL != 0) ? 0 : best, d == 1});
         mCount = 0;
      end
   endtask

   // Monitor: checks traceback sequences and decoded-bit pulses on the falling edge.
   initial begin
      bit dvNext;
      bit doneNext;
      forever begin
         @(negedge Clock);
         if (Reset) begin
            expQ.delete();
            active  = 1'b0;
            dvExp   = 1'b0;
            doneExp = 1'b0;
         end else begin
            dvNext   = 1'b0;
            doneNext = 1'b0;
            check("decoded_valid", 32'(bus.DecodedValid), 32'(dvExp));
            check("frame_done", 32'(bus.FrameDone), 32'(dvExp && doneExp));
            if (bus.DecodedValid) dvCount++;
            if (bus.FrameDone) doneCount++;
            check("ready_vs_tb_en", 32'(bus.AcsReady), 32'(!bus.TB_EN));
            if (bus.TB_EN) begin
               if (bus.Init) begin
                  check("init_while_busy", 32'(active), 0);
                  check("trace_expected", 32'(expQ.size() != 0), 1);
                  if (expQ.size() != 0) begin
                     cur    = expQ.pop_front();
                     active = 1'b1;
                     k      = 0;
                     check("init_state", 32'(bus.InitState), 32'(cur.initSt));
                  end else begin
                     active = 1'b0;
                  end
               end else begin
                  check("tb_without_init", 32'(active), 1);
               end
               if (active) begin
                  check("tb_page", 32'(bus.TbPage), 32'((cur.start - k + PAGES) % PAGES));
                  check("hold", 32'(bus.Hold), 32'(k == cur.depth - 1));
                  if (bus.Hold) begin
                     active   = 1'b0;
                     dvNext   = 1'b1;
                     doneNext = cur.done;
                  end
                  k++;
               end
            end else begin
               check("tb_gap", 32'(active), 0);
               active = 1'b0;
            end
            dvExp   = dvNext;
            doneExp = doneNext;
         end
      end
   end

   task automatic checkReset();
      check("rst_ready", 32'(bus.AcsReady), 1);
      check("rst_wrpage", 32'(bus.WrPage), 0);
      check("rst_tbpage", 32'(bus.TbPage), 0);
      check("rst_tb_en", 32'(bus.TB_EN), 0);
      check("rst_init", 32'(bus.Init), 0);
      check("rst_hold", 32'(bus.Hold), 0);
      check("rst_initstate", 32'(bus.InitState), 0);
      check("rst_dv", 32'(bus.DecodedValid), 0);
      check("rst_framedone", 32'(bus.FrameDone), 0);
   endtask

   // Called just after a falling edge; ends just after a falling edge.
   task automatic resetDut();
      bus.AcsValid  = 1'b0;
      bus.FrameEnd  = 1'b0;
      bus.BestState = '0;
      Reset = 1'b0;
      #1 Reset = 1'b1;
      #1 checkReset();
      @(negedge Clock);
      @(negedge Clock);
      #2 Reset = 1'b0;
      mWrPage = 0;
      mCount  = 0;
      @(negedge Clock);
   endtask

   task automatic doStep(input bit fe, input logic [WD_STATE-1:0] best, input bit keepValid);
      int waitCnt;
      waitCnt       = 0;
      bus.AcsValid  = 1'b1;
      bus.FrameEnd  = fe;
      bus.BestState = best;
      while (!bus.AcsReady && waitCnt < 100) begin
         @(negedge Clock);
         waitCnt++;
      end
      check("accept_ready", 32'(bus.AcsReady), 1);
      if (bus.AcsReady) begin
         check("wr_page", 32'(bus.WrPage), 32'(mWrPage));
         modelAccept(fe, int'(best));
      end
      @(negedge Clock);
      if (!keepValid) begin
         bus.AcsValid = 1'b0;
         bus.FrameEnd = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((expQ.size() != 0 || active || bus.TB_EN) && n < 300) begin
         @(negedge Clock);
         n++;
      end
      @(negedge Clock);
      @(negedge Clock);
      check("drain_idle", 32'({expQ.size() != 0, active, bus.TB_EN}), 0);
   endtask

   task automatic runFrame(input int n, input bit randomize);
      int  dv0;
      int  fd0;
      bit  keep;
      dv0 = dvCount;
      fd0 = doneCount;
      for (int i = 0; i < n; i++) begin
         if (randomize && !bus.AcsValid) begin
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) @(negedge Clock);
         end
         keep = (i != n - 1) && (!randomize || ($urandom_range(0, 1) == 1));
         doStep(i == n - 1, WD_STATE'($urandom_range(0, 255)), keep);
      end
      drain();
      check("frame_bits", 32'(dvCount - dv0), 32'(n));
      check("frame_done_count", 32'(doneCount - fd0), 1);
   endtask

   initial begin
      int dv0;
      bus.AcsValid  = 1'b0;
      bus.FrameEnd  = 1'b0;
      bus.BestState = '0;

      resetDut();

      // Window fill: one traceback from page 3, InitState 5.
      dv0 = dvCount;
      for (int i = 0; i < 3; i++) doStep(1'b0, WD_STATE'($urandom_range(0, 255)), 1'b1);
      doStep(1'b0, WD_STATE'(5), 1'b0);
      drain();
      check("fill_trace_bits", 32'(dvCount - dv0), 1);

      // Continuous stream with AcsValid held through tracebacks; page wrap.
      resetDut();
      dv0 = dvCount;
      for (int i = 0; i < 10; i++) doStep(1'b0, WD_STATE'($urandom_range(0, 255)), i != 9);
      drain();
      check("stream_bits", 32'(dvCount - dv0), 7);

      resetDut();
      runFrame(6, 1'b0);
      runFrame(2, 1'b0);
      runFrame(1, 1'b0);

      // Reset during a traceback.
      resetDut();
      for (int i = 0; i < 4; i++) doStep(1'b0, WD_STATE'($urandom_range(0, 255)), i != 3);
      check("tb_en_before_reset", 32'(bus.TB_EN), 1);
      dv0 = dvCount;
      resetDut();
      drain();
      check("no_pulse_after_reset", 32'(dvCount - dv0), 0);

      for (int f = 0; f < 8; f++) runFrame(int'($urandom_range(1, 11)), 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
